// File: rtl/spec_tag_resolver.sv
// Speculation-tag resolver: allocates in-order tags, collects out-of-order resolutions,
// retires oldest-first with commit or misspeculation broadcast. Optional: SPEC_TAG_RESOLVER_ERR_EN.
module spec_tag_resolver #(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_tag,
    input  logic             resolve_mis,
    output logic             l_valid,
    output logic [TAG_W-1:0] l_status,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic [TAG_W:0]   outstanding
`ifdef SPEC_TAG_RESOLVER_ERR_EN
    ,
    output logic             resolve_err,
    output logic [7:0]       err_count
`endif
);

    localparam int unsigned PTR_W = TAG_W + 1;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [DEPTH-1:0]   done_q, mis_q;

    logic [TAG_W-1:0]   head_idx, tail_idx, rel_idx;
    logic               full, empty, running;
    logic               head_done, head_mis;
    logic               alloc_fire, res_ok;
    logic               retire_commit, retire_mis;

    // Occupancy, ring position of the resolve tag relative to head, and retire decision
    always_comb begin
        outstanding   = tail_q - head_q;
        full          = (outstanding == PTR_W'(DEPTH));
        empty         = (outstanding == '0);
        running       = (state_q == RUN);
        head_idx      = head_q[TAG_W-1:0];
        tail_idx      = tail_q[TAG_W-1:0];
        head_done     = !empty && done_q[head_idx];
        head_mis      = head_done && mis_q[head_idx];
        alloc_ready   = running && !full && !head_mis;
        alloc_tag     = tail_idx;
        alloc_fire    = alloc_req && alloc_ready;
        rel_idx       = resolve_tag - head_idx;
        res_ok        = resolve_valid && running && (PTR_W'(rel_idx) < outstanding)
                        && !done_q[resolve_tag];
        retire_commit = running && head_done && !mis_q[head_idx];
        retire_mis    = running && head_mis;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // SQUASH is a single-cycle state entered on a mispredicted head
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (retire_mis) state_d = SQUASH;
            SQUASH:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Pointers, per-entry status and output pulses; the squash clear is written last so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            done_q       <= '0;
            mis_q        <= '0;
            l_valid      <= 1'b0;
            l_status     <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
        end else begin
            commit_valid <= retire_commit;
            l_valid      <= retire_mis;
            if (alloc_fire) begin
                tail_q           <= tail_q + PTR_W'(1);
                done_q[tail_idx] <= 1'b0;
                mis_q[tail_idx]  <= 1'b0;
            end
            if (res_ok) begin
                done_q[resolve_tag] <= 1'b1;
                mis_q[resolve_tag]  <= resolve_mis;
            end
            if (retire_commit) begin
                commit_tag       <= head_idx;
                head_q           <= head_q + PTR_W'(1);
                done_q[head_idx] <= 1'b0;
            end
            if (retire_mis) begin
                l_status <= head_idx;
                head_q   <= tail_q;
                done_q   <= '0;
                mis_q    <= '0;
            end
        end
    end

`ifdef SPEC_TAG_RESOLVER_ERR_EN
    logic res_rej;
    assign res_rej = resolve_valid && !res_ok;

    // Rejected-resolve pulse and saturating counter
    always_ff @(posedge clk) begin
        if (rst) begin
            resolve_err <= 1'b0;
            err_count   <= '0;
        end else begin
            resolve_err <= res_rej;
            if (res_rej && (err_count != 8'hFF)) err_count <= err_count + 8'(1);
        end
    end
`endif

endmodule
